// File: rtl/wshb_arbiter_2m_if.sv
// Wishbone link bundle shared by the arbiter's master-facing and slave-facing ports.
interface wshb_arbiter_2m_if #(
  parameter int unsigned ADR_W = 32,
  parameter int unsigned DAT_W = 16,
  parameter int unsigned SEL_W = DAT_W / 8
);
  logic             cyc;
  logic             stb;
  logic             we;
  logic [ADR_W-1:0] adr;
  logic [DAT_W-1:0] dat_ms;
  logic [DAT_W-1:0] dat_sm;
  logic [SEL_W-1:0] sel;
  logic [2:0]       cti;
  logic [1:0]       bte;
  logic             ack;

  // Seen from the side that initiates cycles.
  modport master (
    output cyc, stb, we, adr, dat_ms, sel, cti, bte,
    input  ack, dat_sm
  );

  // Seen from the side that answers cycles.
  modport slave (
    input  cyc, stb, we, adr, dat_ms, sel, cti, bte,
    output ack, dat_sm
  );
endinterface

// File: rtl/wshb_arbiter_2m.sv
// Two-master, one-slave Wishbone arbiter. Round-robin at whole-cycle (cyc) granularity,
// no preemption, combinational request mux from registered ownership, per-master ack counters.
module wshb_arbiter_2m (
  input  logic               clk,
  input  logic               rst,
  wshb_arbiter_2m_if.slave   m0,
  wshb_arbiter_2m_if.slave   m1,
  wshb_arbiter_2m_if.master  s,
  output logic [1:0]         grant,
  output logic [31:0]        ack_cnt0,
  output logic [31:0]        ack_cnt1
);

  typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

  state_e      state_q;
  logic        last_q;      // master served most recently; the other wins a tie from idle
  logic [1:0]  grant_q;
  logic [31:0] ack_cnt0_q;
  logic [31:0] ack_cnt1_q;

  // Ownership FSM: hold while the owner keeps cyc, hand over directly when it drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      last_q  <= 1'b0;
      grant_q <= 2'b00;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (m0.cyc && (!m1.cyc || last_q)) begin
            state_q <= StOwn0;
            grant_q <= 2'b01;
          end else if (m1.cyc) begin
            state_q <= StOwn1;
            grant_q <= 2'b10;
          end
        end
        StOwn0: begin
          if (!m0.cyc) begin
            last_q <= 1'b0;
            if (m1.cyc) begin
              state_q <= StOwn1;
              grant_q <= 2'b10;
            end else begin
              state_q <= StIdle;
              grant_q <= 2'b00;
            end
          end
        end
        StOwn1: begin
          if (!m1.cyc) begin
            last_q <= 1'b1;
            if (m0.cyc) begin
              state_q <= StOwn0;
              grant_q <= 2'b01;
            end else begin
              state_q <= StIdle;
              grant_q <= 2'b00;
            end
          end
        end
        default: begin
          state_q <= StIdle;
          grant_q <= 2'b00;
        end
      endcase
    end
  end

  // Request mux and ack routing, both driven straight from the registered owner.
  always_comb begin
    s.cyc    = 1'b0;
    s.stb    = 1'b0;
    s.we     = 1'b0;
    s.adr    = '0;
    s.dat_ms = '0;
    s.sel    = '0;
    s.cti    = '0;
    s.bte    = '0;
    m0.ack   = 1'b0;
    m1.ack   = 1'b0;
    unique case (state_q)
      StOwn0: begin
        s.cyc    = m0.cyc;
        s.stb    = m0.stb;
        s.we     = m0.we;
        s.adr    = m0.adr;
        s.dat_ms = m0.dat_ms;
        s.sel    = m0.sel;
        s.cti    = m0.cti;
        s.bte    = m0.bte;
        m0.ack   = s.ack;
      end
      StOwn1: begin
        s.cyc    = m1.cyc;
        s.stb    = m1.stb;
        s.we     = m1.we;
        s.adr    = m1.adr;
        s.dat_ms = m1.dat_ms;
        s.sel    = m1.sel;
        s.cti    = m1.cti;
        s.bte    = m1.bte;
        m1.ack   = s.ack;
      end
      default: ;
    endcase
  end

  // Read data is broadcast; only the acked master will consume it.
  assign m0.dat_sm = s.dat_sm;
  assign m1.dat_sm = s.dat_sm;

  // Debug counters of acks actually delivered; free-running 32-bit wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_cnt0_q <= '0;
      ack_cnt1_q <= '0;
    end else begin
      if (m0.ack) ack_cnt0_q <= ack_cnt0_q + 32'd1;
      if (m1.ack) ack_cnt1_q <= ack_cnt1_q + 32'd1;
    end
  end

  assign grant    = grant_q;
  assign ack_cnt0 = ack_cnt0_q;
  assign ack_cnt1 = ack_cnt1_q;

endmodule
